// File: rtl/approx_mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : approx_mult_pkg
//  Description : Shared types and width helpers for the approximate
//                sequential multiplier (FSM state encoding, counter widths).
//  Revision    : 1.0  initial release
// ============================================================================
package approx_mult_pkg;

    // Controller states; explicit 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_NORM  = 3'd1,
        ST_MULT  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Width of a per-operand normalisation counter (must hold W-1).
    function automatic int calc_cw(input int w);
        return $clog2(w) + 1;
    endfunction

    // Width of the signed re-scale amount, range 2-2K .. 2W-2K.
    function automatic int calc_sw(input int w);
        return $clog2(2 * w) + 2;
    endfunction

endpackage : approx_mult_pkg
`default_nettype wire

// File: rtl/norm_shreg.sv
`default_nettype none
// ============================================================================
//  Module      : norm_shreg
//  Description : W-bit load / shift-left register used to normalise one
//                operand. Counts how many left shifts were applied and
//                stops shifting by itself once the MSB is set.
//  Ports       : clk, rst (async, active-low), load, shift_en, din[W-1:0],
//                top[TW-1:0] (upper TW bits of the register), cnt[CW-1:0],
//                msb, zero
//  Revision    : 1.0  initial release
// ============================================================================
module norm_shreg
    import approx_mult_pkg::*;
#(
    parameter int W  = 16,
    parameter int TW = 8,
    parameter int CW = calc_cw(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          shift_en,
    input  logic [W-1:0]  din,
    output logic [TW-1:0] top,
    output logic [CW-1:0] cnt,
    output logic          msb,
    output logic          zero
);

    logic [W-1:0]  r_q;
    logic [CW-1:0] r_cnt;

    // A register whose MSB is already set holds, so the controller can
    // assert shift_en for both operands and each one stops on its own.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q   <= '0;
            r_cnt <= '0;
        end else if (load) begin
            r_q   <= din;
            r_cnt <= '0;
        end else if (shift_en && !r_q[W-1]) begin
            r_q   <= {r_q[W-2:0], 1'b0};
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign top  = r_q[W-1:W-TW];
    assign cnt  = r_cnt;
    assign msb  = r_q[W-1];
    assign zero = (r_q == '0);

endmodule : norm_shreg
`default_nettype wire

// File: rtl/approx_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module      : approx_mult_seq
//  Description : Sequential approximate unsigned multiplier. Normalises both
//                operands, multiplies their top K bits and re-scales the
//                2K-bit product one bit per cycle into a 2W-bit result.
//  Ports       : clk, rst (async, active-low), start, a[W-1:0], b[W-1:0],
//                busy, done (1-cycle pulse), res[2W-1:0]
//  Revision    : 1.0  initial release
// ============================================================================
module approx_mult_seq
    import approx_mult_pkg::*;
#(
    parameter int W  = 16,
    parameter int K  = 8,
    parameter int CW = calc_cw(W),
    parameter int SW = calc_sw(W)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] res
);

    state_t         r_state;
    state_t         w_state_nxt;

    logic [2*W-1:0] r_res;
    logic [SW-1:0]  r_sh_cnt;
    logic           r_sh_left;

    logic [K-1:0]   w_a_top, w_b_top;
    logic [CW-1:0]  w_cnt_a, w_cnt_b;
    logic           w_a_msb, w_b_msb;
    logic           w_a_zero, w_b_zero;
    logic           w_load;
    logic           w_norm_shift;
    logic           w_any_zero;
    logic [2*K-1:0] w_p;
    logic [SW-1:0]  w_sh;
    logic [SW-1:0]  w_sh_abs;

    assign w_load       = (r_state == ST_IDLE) && start;
    assign w_any_zero   = w_a_zero || w_b_zero;
    // Only shift while both operands are nonzero and at least one is not
    // yet normalised; a zero operand short-circuits to DONE instead.
    assign w_norm_shift = (r_state == ST_NORM) && !w_any_zero && !(w_a_msb && w_b_msb);

    norm_shreg #(.W(W), .TW(K), .CW(CW)) u_norm_a (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .shift_en (w_norm_shift),
        .din      (a),
        .top      (w_a_top),
        .cnt      (w_cnt_a),
        .msb      (w_a_msb),
        .zero     (w_a_zero)
    );

    norm_shreg #(.W(W), .TW(K), .CW(CW)) u_norm_b (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .shift_en (w_norm_shift),
        .din      (b),
        .top      (w_b_top),
        .cnt      (w_cnt_b),
        .msb      (w_b_msb),
        .zero     (w_b_zero)
    );

    // Truncated multiply of the normalised top bits.
    assign w_p = {{K{1'b0}}, w_a_top} * {{K{1'b0}}, w_b_top};

    // Signed re-scale amount in two's complement; sign bit picks direction.
    assign w_sh     = SW'(2 * W - 2 * K)
                    - {{(SW-CW){1'b0}}, w_cnt_a}
                    - {{(SW-CW){1'b0}}, w_cnt_b};
    assign w_sh_abs = w_sh[SW-1] ? (~w_sh + SW'(1)) : w_sh;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and status outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = ST_NORM;
                end
            end
            ST_NORM: begin
                if (w_any_zero) begin
                    w_state_nxt = ST_DONE;
                end else if (w_a_msb && w_b_msb) begin
                    w_state_nxt = ST_MULT;
                end
            end
            ST_MULT: begin
                w_state_nxt = (w_sh == '0) ? ST_DONE : ST_SHIFT;
            end
            ST_SHIFT: begin
                // Counter holds the shifts still to do, this one included.
                if (r_sh_cnt == SW'(1)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Result register and bit-serial re-scaler
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_res     <= '0;
            r_sh_cnt  <= '0;
            r_sh_left <= 1'b0;
        end else begin
            case (r_state)
                ST_NORM: begin
                    if (w_any_zero) begin
                        r_res <= '0;
                    end
                end
                ST_MULT: begin
                    r_res     <= (2 * W)'(w_p);
                    r_sh_cnt  <= w_sh_abs;
                    r_sh_left <= !w_sh[SW-1];
                end
                ST_SHIFT: begin
                    if (r_sh_left) begin
                        r_res <= {r_res[2*W-2:0], 1'b0};
                    end else begin
                        r_res <= {1'b0, r_res[2*W-1:1]};
                    end
                    r_sh_cnt <= r_sh_cnt - SW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign res = r_res;

endmodule : approx_mult_seq
`default_nettype wire

// File: tb/tb_approx_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_approx_mult_seq
//  Description : Self-checking bench for approx_mult_seq. Two instances
//                (W=16/K=8 and W=8/K=4) are compared every cycle against a
//                transaction-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_approx_mult_seq;

    localparam int W0 = 16;
    localparam int K0 = 8;
    localparam int W1 = 8;
    localparam int K1 = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        start16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16;
    logic [31:0] res16;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [15:0] res8;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model state per instance: phase 0 idle, 1 working, 2 done.
    int              ph      [2] = '{0, 0};
    int              el      [2] = '{0, 0};
    int              lat_exp [2] = '{0, 0};
    longint unsigned pend    [2] = '{0, 0};
    longint unsigned res_exp [2] = '{0, 0};

    always #5 clk = ~clk;

    approx_mult_seq #(.W(W0), .K(K0)) u_dut16 (
        .clk   (clk),
        .rst   (rst),
        .start (start16),
        .a     (a16),
        .b     (b16),
        .busy  (busy16),
        .done  (done16),
        .res   (res16)
    );

    approx_mult_seq #(.W(W1), .K(K1)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .res   (res8)
    );

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        n_chk++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Algorithm-level reference: leading-zero normalise, truncated product,
    // single arithmetic re-scale. Also yields the start-to-done latency.
    function automatic void ref_mul(input int w, input int k,
                                    input longint unsigned av, input longint unsigned bv,
                                    output longint unsigned r, output int lat);
        int ca, cb, sh;
        longint unsigned an, bn, p;
        if (av == 0 || bv == 0) begin
            r   = 0;
            lat = 1;
            return;
        end
        ca = 0; an = av;
        while (((an >> (w - 1)) & 1) == 0) begin an = an << 1; ca++; end
        cb = 0; bn = bv;
        while (((bn >> (w - 1)) & 1) == 0) begin bn = bn << 1; cb++; end
        p  = (an >> (w - k)) * (bn >> (w - k));
        sh = 2 * w - 2 * k - ca - cb;
        r  = (sh >= 0) ? (p << sh) : (p >> (-sh));
        lat = ((ca > cb) ? ca : cb) + ((sh < 0) ? -sh : sh) + 2;
    endfunction

    function automatic logic dn(input int d);
        return (d == 0) ? done16 : done8;
    endfunction

    function automatic longint unsigned rs(input int d);
        return (d == 0) ? longint'(res16) : longint'(res8);
    endfunction

    task automatic set_in(input int d, input logic st, input longint unsigned av, input longint unsigned bv);
        if (d == 0) begin
            start16 = st; a16 = av[15:0]; b16 = bv[15:0];
        end else begin
            start8 = st; a8 = av[7:0]; b8 = bv[7:0];
        end
    endtask

    // Model update on every active edge (and asynchronously on reset).
    initial begin
        forever begin
            @(posedge clk or negedge rst);
            for (int d = 0; d < 2; d++) begin
                if (!rst) begin
                    ph[d]      = 0;
                    res_exp[d] = 0;
                end else begin
                    case (ph[d])
                        0: if ((d == 0) ? start16 : start8) begin
                            if (d == 0) ref_mul(W0, K0, a16, b16, pend[d], lat_exp[d]);
                            else        ref_mul(W1, K1, a8, b8, pend[d], lat_exp[d]);
                            el[d] = 0;
                            ph[d] = 1;
                        end
                        1: begin
                            el[d]++;
                            if (el[d] == lat_exp[d]) begin
                                ph[d]      = 2;
                                res_exp[d] = pend[d];
                            end
                        end
                        default: ph[d] = 0;
                    endcase
                end
            end
        end
    end

    // Compare process: status every cycle, result whenever it is meaningful.
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("dut%0d_busy", d), (d == 0) ? busy16 : busy8, ph[d] != 0);
                chk($sformatf("dut%0d_done", d), dn(d), ph[d] == 2);
                if (ph[d] != 1)
                    chk($sformatf("dut%0d_res", d), rs(d), res_exp[d]);
            end
        end
    end

    // One operation: pulse start, wait (bounded) for done. n counts edges
    // after the accepting edge. A second start pulse is applied n==poke.
    task automatic run_op(input int d, input longint unsigned av, input longint unsigned bv,
                          input int poke, output longint unsigned r, output int n);
        @(negedge clk);
        set_in(d, 1'b1, av, bv);
        @(negedge clk);
        set_in(d, 1'b0, av, bv);
        n = 0;
        while (!dn(d) && n < 200) begin
            @(negedge clk);
            n++;
            if (n == poke) set_in(d, 1'b1, 64'hFFFF, 64'hFFFF);
            else           set_in(d, 1'b0, av, bv);
        end
        if (!dn(d)) chk($sformatf("dut%0d_timeout", d), 0, 1);
        r = rs(d);
    endtask

    typedef struct {
        int              d;
        longint unsigned av, bv, r;
        int              lat;
    } vec_t;

    initial begin
        vec_t            dir [6];
        longint unsigned r, mr;
        int              n, ml, cnt;

        dir[0] = '{0, 64'h1234, 64'h5678, 64'h0616C000, 17};
        dir[1] = '{0, 64'hFFFF, 64'hFFFF, 64'hFE010000, 18};
        dir[2] = '{0, 64'h0001, 64'h0003, 64'h00000003, 30};
        dir[3] = '{0, 64'h0000, 64'h1234, 64'h0,         1};
        dir[4] = '{0, 64'hABCD, 64'h0000, 64'h0,         1};
        dir[5] = '{1, 64'h30,   64'h05,   64'h00F0,      8};

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_busy", busy16, 0);
        chk("rst_done", done16, 0);
        chk("rst_res",  res16,  0);
        #2 rst = 1'b1;

        // Pin the model with hand-computed values, then run the same
        // vectors through the DUTs.
        foreach (dir[i]) begin
            ref_mul(dir[i].d ? W1 : W0, dir[i].d ? K1 : K0, dir[i].av, dir[i].bv, mr, ml);
            chk($sformatf("model%0d_res", i), mr, dir[i].r);
            chk($sformatf("model%0d_lat", i), ml, dir[i].lat);
            run_op(dir[i].d, dir[i].av, dir[i].bv, -1, r, n);
            chk($sformatf("dir%0d_res", i), r, dir[i].r);
            chk($sformatf("dir%0d_lat", i), n, dir[i].lat);
        end

        // Start pulse while the re-scaler is running is ignored.
        run_op(0, 64'h1234, 64'h5678, 8, r, n);
        chk("midshift_res", r, 64'h0616C000);
        chk("midshift_lat", n, 17);

        // Start held high: back-to-back operations, each with a 1-cycle done.
        @(negedge clk);
        set_in(0, 1'b1, 64'h1234, 64'h5678);
        cnt = 0;
        repeat (37) begin
            @(negedge clk);
            if (done16) cnt++;
        end
        set_in(0, 1'b0, 64'h1234, 64'h5678);
        repeat (3) @(negedge clk);
        chk("b2b_dones", cnt, 2);

        // Reset in the middle of SHIFT clears everything at once.
        set_in(0, 1'b1, 64'h1234, 64'h5678);
        @(negedge clk);
        set_in(0, 1'b0, 64'h1234, 64'h5678);
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_busy", busy16, 0);
        chk("midrst_done", done16, 0);
        chk("midrst_res",  res16,  0);
        @(negedge clk);
        #2 rst = 1'b1;
        run_op(0, 64'h1234, 64'h5678, -1, r, n);
        chk("postrst_res", r, 64'h0616C000);
        chk("postrst_lat", n, 17);

        // Randomised operands with varied leading-zero counts.
        for (int i = 0; i < 1000; i++) begin
            int              d, w;
            longint unsigned av, bv, msk;
            d   = (i < 600) ? 0 : 1;
            w   = d ? W1 : W0;
            msk = (64'd1 << w) - 1;
            av  = (longint'($urandom) & msk) >> $urandom_range(0, w);
            bv  = (longint'($urandom) & msk) >> $urandom_range(0, w);
            ref_mul(w, d ? K1 : K0, av, bv, mr, ml);
            run_op(d, av, bv, -1, r, n);
            chk($sformatf("rnd%0d_res", i), r, mr);
            chk($sformatf("rnd%0d_lat", i), n, ml);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

endmodule : tb_approx_mult_seq
`default_nettype wire

// File: doc/approx_mult_seq.md
Name: approx_mult_seq

Overview:
Sequential approximate unsigned multiplier with a start/done handshake, parametrised in operand width W and truncated multiplier width K.
- Normalises both operands by shifting each left until its MSB is 1, counting the shifts per operand.
- Multiplies the top K bits of each normalised operand.
- Re-scales the product by bit-serial shifting to form a 2W-bit result.
- Controller and datapath live in one block; it serves as the drop-in multiply engine for the accelerator datapath.

Parameters:
W, 16, operand width in bits; legal range W >= 2.
K, 8, width of the truncated multiplier inputs; legal range 1 <= K <= W.
CW, $clog2(W)+1, width of each normalisation shift counter (derived; do not override).
SW, $clog2(2*W)+2, width of the signed re-scale amount (derived; do not override).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  request; sampled only in IDLE
a  in  W  operand A, unsigned; sampled on the accepting edge only
b  in  W  operand B, unsigned; sampled on the accepting edge only
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse; res is valid while done is high
res  out  2W  approximate product

Behaviour:
- Reset: asynchronous, active-low (rst=0); clk is the only clock. While rst=0: state=IDLE; a_reg, b_reg, cnt_a, cnt_b, shift counter and res all 0; busy=0; done=0. This holds mid-operation too; any operation in progress is discarded.
- FSM states: IDLE, NORM, MULT, SHIFT, DONE.
- IDLE: on an edge with start=1, load a_reg<=a, b_reg<=b, cnt_a<=0, cnt_b<=0, then go to NORM. res is held.
- NORM, checked in this priority order each cycle:
  - if a_reg==0 or b_reg==0: res<=0, go to DONE.
  - else if a_reg[W-1]==1 and b_reg[W-1]==1: go to MULT.
  - else each operand whose MSB is 0 shifts left by 1 and increments its counter. An operand already normalised holds its value. Maximum count is W-1.
- MULT:
  - p = a_reg[W-1:W-K] * b_reg[W-1:W-K], 2K bits.
  - res <= p zero-extended to 2W bits.
  - sh = (2W-2K) - cnt_a - cnt_b, signed SW bits.
  - Shift counter <= |sh|; direction = left if sh>0, right if sh<0.
  - Next state: SHIFT if sh!=0, else DONE.
- SHIFT: each cycle res shifts by 1 in the latched direction, with zero fill; the counter decrements. Once the final shift is performed, go to DONE. Right shifts truncate low bits.
- DONE: done=1 for exactly this cycle, then go to IDLE.
  - res stays stable from DONE until the next operation's MULT or zero-case write.
  - res values are not meaningful while busy=1.
- start while busy: ignored. If start is still high in IDLE after DONE, a new operation begins on that edge (back-to-back is allowed).
- Latency, start edge to done high: N = max(cnt_a,cnt_b) + |sh| + 2 edges. Zero operand: N = 1.
- No overflow is possible: |p| < 2^(2K) and the left shift is at most 2W-2K.

Decomposition:
- Package approx_mult_pkg: state enum (IDLE, NORM, MULT, SHIFT, DONE), and the CW/SW width functions.
- One natural sub-module: norm_shreg, a W-bit load/shift-left register with a CW-bit shift counter and an msb/zero flag. Instantiate it twice.
- The truncated multiply and the result shifter stay inline.

Test Plan:
1. W=16, K=8, a=0x1234, b=0x5678 -> cnt_a=3, cnt_b=1, p=0x616C, sh=12; res=0x0616C000; done 17 edges after start; busy high throughout.
2. a=0xFFFF, b=0xFFFF -> cnt 0/0, p=0xFE01, sh=16; res=0xFE010000; N=18.
3. a=0x0001, b=0x0003 -> cnt_a=15, cnt_b=14, p=0x6000, sh=-13; res=0x00000003 (exact); N=30.
4. a=0x0000, b=0x1234 -> res=0, done 1 edge after start. Then a=0xABCD, b=0 -> res=0, N=1.
5. Handshake and reset:
   - Pulse start again mid-SHIFT of case 1 -> ignored, result unchanged.
   - Hold start high for 40 cycles -> two back-to-back results, each with a 1-cycle done.
   - Drop rst mid-SHIFT -> busy=0, done=0, res=0 immediately; the next start yields correct results.
6. W=8, K=4, a=0x30, b=0x05 -> cnt_a=2, cnt_b=5, p=0x78, sh=1; res=0x00F0; N=8. Also a randomised run of 1000 vectors against the reference model (same algorithm in the bench) -> bit-exact match.
